// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// branch_cond_unit
//
// Registered branch-condition unit for the multicycle datapath. It compares
// two operands (signed or unsigned), stores the Zero/Gt/Lt outcome in a flag
// register, and on request evaluates one of eight branch conditions against
// the stored flags. The decision is registered and qualified by a one-cycle
// TakenValid pulse for the PC-write control. Saturating counters record how
// many evaluations were accepted and how many of them were taken.
//
// Parameters
//   DATA_WIDTH : operand width (>= 2)
//   CNT_WIDTH  : width of the statistics counters
//   CONSUME    : 1 -> flags are invalidated by each accepted evaluation
//                0 -> flags persist until the next CmpLoad or reset
//
// Ports
//   clk         in   system clock, rising-edge active
//   reset       in   synchronous active-high reset
//   CmpLoad     in   capture compare(A, B) into the flag register
//   A, B        in   operands
//   Unsigned    in   1: unsigned compare, 0: two's-complement compare
//   BranchEval  in   evaluate BranchCtrl against the stored flags
//   BranchCtrl  in   condition select
//   BranchTaken out  registered decision, held until the next accepted eval
//   TakenValid  out  one-cycle pulse after an accepted evaluation
//   EvalErr     out  one-cycle pulse after an evaluation with no valid flags
//   FlagsValid  out  flag register holds a usable comparison
//   Zero/Gt/Lt  out  registered flags
//   EvalCount   out  accepted evaluations, saturating
//   TakenCount  out  taken evaluations, saturating
//
// Condition codes
//   000 eq  001 ne  010 gt  011 le  100 lt  101 ge  110 always  111 never
// ---------------------------------------------------------------------------
module branch_cond_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int CONSUME    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CmpLoad,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Unsigned,
  input  logic                  BranchEval,
  input  logic [2:0]            BranchCtrl,
  output logic                  BranchTaken,
  output logic                  TakenValid,
  output logic                  EvalErr,
  output logic                  FlagsValid,
  output logic                  Zero,
  output logic                  Gt,
  output logic                  Lt,
  output logic [CNT_WIDTH-1:0]  EvalCount,
  output logic [CNT_WIDTH-1:0]  TakenCount
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                 r_branch_taken;
  logic                 r_taken_valid;
  logic                 r_eval_err;
  logic                 r_flags_valid;
  logic                 r_zero;
  logic                 r_gt;
  logic                 r_lt;
  logic [CNT_WIDTH-1:0] r_eval_count;
  logic [CNT_WIDTH-1:0] r_taken_count;

  // -------------------------------------------------------------------------
  // Operand comparison
  // -------------------------------------------------------------------------
  logic w_eq;
  logic w_gt_u;
  logic w_lt_u;
  logic w_gt_s;
  logic w_lt_s;
  logic w_gt;
  logic w_lt;

  assign w_eq   = (A == B);
  assign w_gt_u = (A > B);
  assign w_lt_u = (A < B);
  assign w_gt_s = ($signed(A) > $signed(B));
  assign w_lt_s = ($signed(A) < $signed(B));
  assign w_gt   = Unsigned ? w_gt_u : w_gt_s;
  assign w_lt   = Unsigned ? w_lt_u : w_lt_s;

  // -------------------------------------------------------------------------
  // Condition table, indexed by BranchCtrl. Built from the flags held before
  // the current edge, so a simultaneous CmpLoad never forwards into the
  // evaluation.
  // -------------------------------------------------------------------------
  logic [7:0] w_cond_table;
  logic       w_cond;

  assign w_cond_table[0] =  r_zero;   // eq
  assign w_cond_table[1] = ~r_zero;   // ne
  assign w_cond_table[2] =  r_gt;     // gt
  assign w_cond_table[3] = ~r_gt;     // le
  assign w_cond_table[4] =  r_lt;     // lt
  assign w_cond_table[5] = ~r_lt;     // ge
  assign w_cond_table[6] =  1'b1;     // always
  assign w_cond_table[7] =  1'b0;     // never

  assign w_cond = w_cond_table[BranchCtrl];

  // -------------------------------------------------------------------------
  // Evaluation qualification
  // -------------------------------------------------------------------------
  logic w_accept;
  logic w_reject;
  logic w_consume;

  assign w_accept  = BranchEval &  r_flags_valid;
  assign w_reject  = BranchEval & ~r_flags_valid;
  assign w_consume = (CONSUME != 0);

  // -------------------------------------------------------------------------
  // Saturating counter increments
  // -------------------------------------------------------------------------
  logic                 w_eval_sat;
  logic                 w_taken_sat;
  logic [CNT_WIDTH-1:0] w_eval_count_next;
  logic [CNT_WIDTH-1:0] w_taken_count_next;

  assign w_eval_sat  = &r_eval_count;
  assign w_taken_sat = &r_taken_count;

  always_comb begin
    w_eval_count_next  = r_eval_count;
    w_taken_count_next = r_taken_count;
    if (w_accept) begin
      if (!w_eval_sat) begin
        w_eval_count_next = r_eval_count + 1'b1;
      end
      if (w_cond && !w_taken_sat) begin
        w_taken_count_next = r_taken_count + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_taken <= 1'b0;
      r_taken_valid  <= 1'b0;
      r_eval_err     <= 1'b0;
      r_flags_valid  <= 1'b0;
      r_zero         <= 1'b0;
      r_gt           <= 1'b0;
      r_lt           <= 1'b0;
      r_eval_count   <= '0;
      r_taken_count  <= '0;
    end else begin
      // Pulses are rewritten every cycle so they last exactly one cycle.
      r_taken_valid <= w_accept;
      r_eval_err    <= w_reject;

      if (w_accept) begin
        r_branch_taken <= w_cond;
      end

      r_eval_count  <= w_eval_count_next;
      r_taken_count <= w_taken_count_next;

      // A load always wins over consumption: the fresh comparison is valid
      // even when the same edge consumed the previous one.
      if (CmpLoad) begin
        r_zero        <= w_eq;
        r_gt          <= w_gt;
        r_lt          <= w_lt;
        r_flags_valid <= 1'b1;
      end else if (w_accept && w_consume) begin
        r_flags_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign BranchTaken = r_branch_taken;
  assign TakenValid  = r_taken_valid;
  assign EvalErr     = r_eval_err;
  assign FlagsValid  = r_flags_valid;
  assign Zero        = r_zero;
  assign Gt          = r_gt;
  assign Lt          = r_lt;
  assign EvalCount   = r_eval_count;
  assign TakenCount  = r_taken_count;

endmodule

// File: tb/tb_branch_cond_unit.sv
// ---------------------------------------------------------------------------
// Testbench for branch_cond_unit. Two instances share one stimulus stream:
//   u0 : CONSUME=1, CNT_WIDTH=16
//   u1 : CONSUME=0, CNT_WIDTH=2  (saturation reachable quickly)
// The driver computes the expected outputs from a behavioural model and
// pushes them into a per-instance queue; the monitor pops one entry per
// clock and compares it with what each instance presents.
// ---------------------------------------------------------------------------
module tb_branch_cond_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmp_load = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          uns = 1'b0;
  logic          br_eval = 1'b0;
  logic [2:0]    br_ctrl = 3'b000;

  logic        tk0, tv0, er0, fv0, z0, g0, l0;
  logic [15:0] ec0, tc0;
  logic        tk1, tv1, er1, fv1, z1, g1, l1;
  logic [1:0]  ec1, tc1;

  always #5 clk = ~clk;

  branch_cond_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .CONSUME(1)) u0 (
    .clk(clk), .reset(reset), .CmpLoad(cmp_load), .A(a_in), .B(b_in),
    .Unsigned(uns), .BranchEval(br_eval), .BranchCtrl(br_ctrl),
    .BranchTaken(tk0), .TakenValid(tv0), .EvalErr(er0), .FlagsValid(fv0),
    .Zero(z0), .Gt(g0), .Lt(l0), .EvalCount(ec0), .TakenCount(tc0)
  );

  branch_cond_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(2), .CONSUME(0)) u1 (
    .clk(clk), .reset(reset), .CmpLoad(cmp_load), .A(a_in), .B(b_in),
    .Unsigned(uns), .BranchEval(br_eval), .BranchCtrl(br_ctrl),
    .BranchTaken(tk1), .TakenValid(tv1), .EvalErr(er1), .FlagsValid(fv1),
    .Zero(z1), .Gt(g1), .Lt(l1), .EvalCount(ec1), .TakenCount(tc1)
  );

  typedef struct {
    bit tk, tv, er, fv, z, g, l;
    int ec, tc;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;

  // ---------------- behavioural reference ----------------
  bit m_v[2], m_z[2], m_g[2], m_l[2], m_tk[2];
  int m_ec[2], m_tc[2];
  int m_cmax[2]    = '{65535, 3};
  bit m_consume[2] = '{1'b1, 1'b0};

  function automatic bit cond_of(bit [2:0] c, bit z, bit g, bit l);
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return g;
      3'd3: return !g;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input int k, input bit rst, input bit cl,
                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input bit u, input bit be, input bit [2:0] bc,
                            output exp_t e);
    longint av, bv;
    bit acc, res;
    e.tv = 1'b0;
    e.er = 1'b0;
    if (rst) begin
      m_v[k] = 0; m_z[k] = 0; m_g[k] = 0; m_l[k] = 0; m_tk[k] = 0;
      m_ec[k] = 0; m_tc[k] = 0;
    end else begin
      acc  = be && m_v[k];
      e.tv = acc;
      e.er = be && !m_v[k];
      if (acc) begin
        res = cond_of(bc, m_z[k], m_g[k], m_l[k]);
        m_tk[k] = res;
        if (m_ec[k] < m_cmax[k]) m_ec[k]++;
        if (res && m_tc[k] < m_cmax[k]) m_tc[k]++;
      end
      if (cl) begin
        av = u ? longint'(a) : longint'($signed(a));
        bv = u ? longint'(b) : longint'($signed(b));
        m_z[k] = (av == bv);
        m_g[k] = (av > bv);
        m_l[k] = (av < bv);
        m_v[k] = 1'b1;
      end else if (acc && m_consume[k]) begin
        m_v[k] = 1'b0;
      end
    end
    e.tk = m_tk[k]; e.fv = m_v[k];
    e.z = m_z[k]; e.g = m_g[k]; e.l = m_l[k];
    e.ec = m_ec[k]; e.tc = m_tc[k];
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit rst, input bit cl, input logic [DW-1:0] a,
                     input logic [DW-1:0] b, input bit u, input bit be,
                     input bit [2:0] bc);
    exp_t e;
    @(negedge clk);
    reset = rst; cmp_load = cl; a_in = a; b_in = b; uns = u;
    br_eval = be; br_ctrl = bc;
    cycle++;
    model_step(0, rst, cl, a, b, u, be, bc, e); e.cyc = cycle; q0.push_back(e);
    model_step(1, rst, cl, a, b, u, be, bc, e); e.cyc = cycle; q1.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 0, '0, '0, 0, 0, 3'd0);
  endtask

  task automatic load(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit u);
    cyc(0, 1, a, b, u, 0, 3'd0);
  endtask

  task automatic eval(input bit [2:0] bc);
    cyc(0, 0, '0, '0, 0, 1, bc);
  endtask

  // ---------------- monitor ----------------
  function automatic void check(input string name, input int inst,
                                input int act, input int exp_v, input int cy);
    checks++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s u%0d cycle %0d: got %0d expected %0d", name, inst, cy, act, exp_v);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("BranchTaken", 0, int'(tk0), int'(e.tk), e.cyc);
        check("TakenValid",  0, int'(tv0), int'(e.tv), e.cyc);
        check("EvalErr",     0, int'(er0), int'(e.er), e.cyc);
        check("FlagsValid",  0, int'(fv0), int'(e.fv), e.cyc);
        check("Zero",        0, int'(z0),  int'(e.z),  e.cyc);
        check("Gt",          0, int'(g0),  int'(e.g),  e.cyc);
        check("Lt",          0, int'(l0),  int'(e.l),  e.cyc);
        check("EvalCount",   0, int'(ec0), e.ec,       e.cyc);
        check("TakenCount",  0, int'(tc0), e.tc,       e.cyc);
        if (e.tv || e.er)
          $display("cycle %0d u0 eval: taken=%0b valid=%0b err=%0b evals=%0d taken_cnt=%0d",
                   e.cyc, tk0, tv0, er0, ec0, tc0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("BranchTaken", 1, int'(tk1), int'(e.tk), e.cyc);
        check("TakenValid",  1, int'(tv1), int'(e.tv), e.cyc);
        check("EvalErr",     1, int'(er1), int'(e.er), e.cyc);
        check("FlagsValid",  1, int'(fv1), int'(e.fv), e.cyc);
        check("Zero",        1, int'(z1),  int'(e.z),  e.cyc);
        check("Gt",          1, int'(g1),  int'(e.g),  e.cyc);
        check("Lt",          1, int'(l1),  int'(e.l),  e.cyc);
        check("EvalCount",   1, int'(ec1), e.ec,       e.cyc);
        check("TakenCount",  1, int'(tc1), e.tc,       e.cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] ra, rb;
    int sel;
    int waited;

    // Reset, then evaluation with no flags -> EvalErr
    cyc(1, 0, '0, '0, 0, 0, 3'd0);
    cyc(1, 0, '0, '0, 0, 0, 3'd0);
    eval(3'd0);
    idle();

    // Equal operands, eq taken; second eval errors on the consuming instance
    load(32'd5, 32'd5, 0);
    eval(3'd0);
    eval(3'd0);
    idle();

    // -1 vs 1 signed and unsigned
    load(32'hFFFF_FFFF, 32'd1, 0);
    eval(3'd4);
    load(32'hFFFF_FFFF, 32'd1, 1);
    eval(3'd2);
    load(32'hFFFF_FFFF, 32'd1, 1);
    eval(3'd3);

    // One load, eight consecutive evaluations over all codes
    cyc(1, 0, '0, '0, 0, 0, 3'd0);
    load(32'd3, 32'd7, 0);
    for (int c = 0; c < 8; c++) eval(3'(c));
    idle();

    // Simultaneous load and eval: old flags Zero=1 used, new flags loaded
    load(32'd5, 32'd5, 0);
    cyc(0, 1, 32'd9, 32'd2, 0, 1, 3'd2);
    eval(3'd2);
    idle();

    // Simultaneous load and eval with no valid flags: error, load still happens
    cyc(1, 0, '0, '0, 0, 0, 3'd0);
    cyc(0, 1, 32'd4, 32'd4, 0, 1, 3'd0);
    idle();

    // Saturation: keep flags valid with load each cycle, 5+ "always" evals
    cyc(1, 0, '0, '0, 0, 0, 3'd0);
    load(32'd1, 32'd1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 32'd1, 32'd1, 0, 1, 3'd6);
    idle();

    // Reset asserted together with load and eval
    cyc(1, 1, 32'd8, 32'd3, 0, 1, 3'd6);
    idle();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 3));
      ra  = (sel == 0) ? $urandom : DW'($urandom_range(0, 3));
      rb  = (sel == 1) ? $urandom : ((sel == 2) ? ra : DW'($urandom_range(0, 3)));
      if (sel == 3) begin
        ra = {1'b1, ra[DW-2:0]};
      end
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), ra, rb,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          3'($urandom_range(0, 7)));
    end
    idle();

    waited = 0;
    while ((q0.size() > 0 || q1.size() > 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries expected 0", q0.size() + q1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Registered, parametrised branch-condition unit for the multicycle datapath; successor to the 2-bit combinational branch-select mux.
- Compares two operands itself (signed or unsigned) and latches Zero/Gt/Lt flags on CmpLoad.
- Evaluates one of 8 branch conditions on BranchEval, producing a registered BranchTaken with a 1-cycle valid pulse for the PC-write control.
- Keeps saturating evaluation and taken counters for debug.

Parameters:
- DATA_WIDTH, 32, operand width (>= 2).
- CNT_WIDTH, 16, width of the statistics counters.
- CONSUME, 1, if 1, flags are invalidated after each successful evaluation; if 0, flags persist until the next CmpLoad or reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- CmpLoad  in  1  capture comparison of A/B into the flag register this cycle.
- A  in  DATA_WIDTH  operand A.
- B  in  DATA_WIDTH  operand B.
- Unsigned  in  1  when 1, Gt/Lt use unsigned compare; when 0, two's-complement signed compare; sampled with CmpLoad.
- BranchEval  in  1  request evaluation of BranchCtrl against the stored flags.
- BranchCtrl  in  3  condition select, sampled with BranchEval.
- BranchTaken  out  1  registered decision; holds its value until the next valid evaluation.
- TakenValid  out  1  one-cycle pulse, the cycle after an accepted BranchEval.
- EvalErr  out  1  one-cycle pulse, the cycle after a BranchEval issued with FlagsValid=0.
- FlagsValid  out  1  flag register holds a valid comparison.
- Zero, Gt, Lt  out  1 each  registered flags.
- EvalCount  out  CNT_WIDTH  accepted evaluations, saturating.
- TakenCount  out  CNT_WIDTH  evaluations with result 1, saturating.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset:
  - all outputs 0; all counters 0; FlagsValid=0.
  - reset has priority over every other input in the same cycle, including mid-sequence with CmpLoad/BranchEval high.
- Flag load, on the edge where CmpLoad=1:
  - Zero <= (A==B).
  - Gt <= A>B and Lt <= A<B, signed or unsigned per Unsigned.
  - FlagsValid <= 1.
  - Exactly one of Zero/Gt/Lt is 1 after a load.
- Condition encoding, on the stored flags:
  - 000 eq = Zero; 001 ne = ~Zero.
  - 010 gt = Gt; 011 le = ~Gt.
  - 100 lt = Lt; 101 ge = ~Lt.
  - 110 always = 1; 111 never = 0.
  - Codes 00/01 match the legacy mux's Zero/ZeroNegado; legacy 10/11 map to 010/011.
- Evaluation, BranchEval=1 and FlagsValid=1 ("accepted"):
  - next edge: BranchTaken <= cond result; TakenValid <= 1.
  - EvalCount increments; TakenCount increments if the result is 1.
  - Latency: 1 cycle from BranchEval to BranchTaken/TakenValid.
- Evaluation, BranchEval=1 and FlagsValid=0:
  - next edge: EvalErr <= 1; TakenValid=0; BranchTaken and counters unchanged.
- Pulse outputs: TakenValid and EvalErr are 0 in every cycle not directly following a qualifying BranchEval.
- Simultaneous CmpLoad and BranchEval:
  - evaluation uses the flags held before this edge; no forwarding.
  - the new flags are loaded on the same edge and FlagsValid ends at 1, regardless of CONSUME.
  - if FlagsValid was 0, EvalErr pulses and the load still occurs.
- CONSUME=1: an accepted evaluation without a simultaneous CmpLoad clears FlagsValid; flag values are retained but invalid.
- Back-to-back BranchEval:
  - CONSUME=0: accepted every cycle.
  - CONSUME=1: the second evaluation errors unless a CmpLoad intervened.
- Counters saturate at all-ones; no wrap.

Test Plan:
- Reset, then BranchEval=1 with BranchCtrl=000 -> next cycle EvalErr=1, TakenValid=0, EvalCount=0.
- CmpLoad with A=5, B=5 -> Zero=1/Gt=0/Lt=0; BranchEval with 000 -> next cycle BranchTaken=1, TakenValid=1, EvalCount=1, TakenCount=1; with CONSUME=1, FlagsValid=0 afterwards.
- CmpLoad with A=32'hFFFFFFFF, B=1: Unsigned=0 -> Lt=1, code 100 taken; Unsigned=1 -> Gt=1, code 010 taken, code 011 not taken.
- CONSUME=0: one CmpLoad (A=3, B=7), then 8 consecutive evaluations with codes 000..111 -> results 0,1,0,1,1,0,1,0; TakenValid high for 8 cycles; EvalCount=8, TakenCount=4.
- Same cycle: CmpLoad (A=9, B=2) and BranchEval with 010, old flags Zero=1 -> BranchTaken=0, then Gt=1 and FlagsValid=1.
- CNT_WIDTH=2: 5 accepted evaluations with code 110 -> EvalCount=TakenCount=3 (saturated).
- Reset asserted together with CmpLoad/BranchEval -> next cycle all outputs 0, no pulse.
